pool_tile_sched: RTL and testbench

- Sequences the pooling output buffer over a 2-D grid of image tiles, row-major.
- Per tile it drives the geometry/padding configuration, starts compute, waits for the buffer's pad_end, issues tile_dump once the global buffer is ready, and waits for dump_end.
- Sits between the top-level layer controller and the pool buffer / lb_2_glb path.

---
 rtl/pool_tile_sched.sv | 214 +++++++++++++++++++++
 tb/tb_pool_tile_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_tile_sched.sv
// Purpose: walks the pool buffer over a row-major tile grid (config, go, wait fill, dump, wait drain).
// Latency: config check 1 cycle after start; tile_go 2 cycles after entering a tile; tile_dump 1 cycle after glb_ready.
// Backpressure: DUMP_REQ stalls indefinitely while glb_ready is low; pad_end/dump_end are waited on without timeout.
//
// Ports:
//   clock, rst_n                  clock and asynchronous active-low reset
//   start, abort                  layer start pulse (IDLE only) and abort request
//   cfg_*                         layer geometry, captured when start is accepted
//   pad_end, dump_end, glb_ready  pool buffer / global buffer handshakes
//   tile_length_to_qtf .. pad_size  latched geometry for the datapath
//   pad_mod_sel                   pad mode (1..9) of the current tile
//   tile_go, tile_dump, done      single-cycle pulses
//   tile_x, tile_y, busy, cfg_err current tile position, layer active, sticky config error
module pool_tile_sched #(
    parameter int POOL_SIZE = 2,
    parameter int MAX_DIM   = 31
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] cfg_tiles_x,
    input  logic [3:0] cfg_tiles_y,
    input  logic [5:0] cfg_tile_length,
    input  logic [5:0] cfg_tile_height,
    input  logic [2:0] cfg_ksize,
    input  logic [2:0] cfg_stride,
    input  logic [2:0] cfg_pad_size,
    input  logic       pad_end,
    input  logic       dump_end,
    input  logic       glb_ready,
    output logic [5:0] tile_length_to_qtf,
    output logic [5:0] tile_height_to_qtf,
    output logic [2:0] ksize,
    output logic [2:0] stride,
    output logic [2:0] pad_size,
    output logic [3:0] pad_mod_sel,
    output logic       tile_go,
    output logic       tile_dump,
    output logic [3:0] tile_x,
    output logic [3:0] tile_y,
    output logic       busy,
    output logic       done,
    output logic       cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT_POOL,
        S_DUMP_REQ,
        S_WAIT_DUMP
    } state_t;

    state_t     state;
    logic [3:0] tiles_x_q;
    logic [3:0] tiles_y_q;
    logic       abort_pend;

    // Pooled output size of the latched geometry; only evaluated in CHECK.
    logic [2:0] s_div;
    logic [6:0] l_diff, h_diff;
    logic [6:0] l_out, h_out;
    logic [6:0] lp, hp;
    logic       cfg_bad;

    always_comb begin
        // Divisor forced non-zero; a zero stride is rejected separately.
        s_div   = (stride == 3'd0) ? 3'd1 : stride;
        // Underflow when k exceeds L/H is harmless: that case is flagged below.
        l_diff  = {1'b0, tile_length_to_qtf} - {4'b0, ksize};
        h_diff  = {1'b0, tile_height_to_qtf} - {4'b0, ksize};
        l_out   = (l_diff / {4'b0, s_div}) + 7'd1;
        h_out   = (h_diff / {4'b0, s_div}) + 7'd1;
        lp      = l_out / 7'(POOL_SIZE);
        hp      = h_out / 7'(POOL_SIZE);
        cfg_bad = (stride == 3'd0) || (ksize == 3'd0)
               || ({3'b0, ksize} > tile_length_to_qtf)
               || ({3'b0, ksize} > tile_height_to_qtf)
               || (tiles_x_q == 4'd0) || (tiles_y_q == 4'd0)
               || (lp == 7'd0) || (hp == 7'd0)
               || (({1'b0, lp} + 8'(pad_size)) > 8'(MAX_DIM))
               || (({1'b0, hp} + 8'(pad_size)) > 8'(MAX_DIM));
    end

    // Grid position bookkeeping for the advance out of WAIT_DUMP.
    logic       at_last_col;
    logic       at_last_tile;
    logic [3:0] nxt_x, nxt_y;

    always_comb begin
        at_last_col  = (tile_x == tiles_x_q - 4'd1);
        at_last_tile = at_last_col && (tile_y == tiles_y_q - 4'd1);
        nxt_x        = at_last_col ? 4'd0 : tile_x + 4'd1;
        nxt_y        = at_last_col ? tile_y + 4'd1 : tile_y;
    end

    // Edge classification checks first/top edge before last/bottom edge,
    // so a single row or column is treated as top/left.
    function automatic logic [3:0] mode_of(input logic [3:0] x, input logic [3:0] y,
                                           input logic [3:0] nx, input logic [3:0] ny);
        logic [1:0] rc, cc;
        rc = (y == 4'd0) ? 2'd0 : ((y == ny - 4'd1) ? 2'd2 : 2'd1);
        cc = (x == 4'd0) ? 2'd0 : ((x == nx - 4'd1) ? 2'd2 : 2'd1);
        return ({2'b0, rc} * 4'd3) + {2'b0, cc} + 4'd1;
    endfunction

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state              <= S_IDLE;
            tiles_x_q          <= '0;
            tiles_y_q          <= '0;
            abort_pend         <= 1'b0;
            tile_length_to_qtf <= '0;
            tile_height_to_qtf <= '0;
            ksize              <= '0;
            stride             <= '0;
            pad_size           <= '0;
            pad_mod_sel        <= '0;
            tile_go            <= 1'b0;
            tile_dump          <= 1'b0;
            tile_x             <= '0;
            tile_y             <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cfg_err            <= 1'b0;
        end else begin
            tile_go   <= 1'b0;
            tile_dump <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        tiles_x_q          <= cfg_tiles_x;
                        tiles_y_q          <= cfg_tiles_y;
                        tile_length_to_qtf <= cfg_tile_length;
                        tile_height_to_qtf <= cfg_tile_height;
                        ksize              <= cfg_ksize;
                        stride             <= cfg_stride;
                        pad_size           <= cfg_pad_size;
                        busy               <= 1'b1;
                        cfg_err            <= 1'b0;
                        tile_x             <= '0;
                        tile_y             <= '0;
                        abort_pend         <= 1'b0;
                        state              <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort || cfg_bad) begin
                        cfg_err <= cfg_bad && !abort;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        pad_mod_sel <= mode_of(4'd0, 4'd0, tiles_x_q, tiles_y_q);
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tile_go <= 1'b1;
                        state   <= S_WAIT_POOL;
                    end
                end
                S_WAIT_POOL: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (pad_end) begin
                        state <= S_DUMP_REQ;
                    end
                end
                S_DUMP_REQ: begin
                    if (abort) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (glb_ready) begin
                        tile_dump <= 1'b1;
                        state     <= S_WAIT_DUMP;
                    end
                end
                S_WAIT_DUMP: begin
                    // A dump in flight must complete so the pool buffer clears;
                    // abort is only honoured once dump_end arrives.
                    if (dump_end) begin
                        if (abort || abort_pend || at_last_tile) begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            abort_pend <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            tile_x      <= nxt_x;
                            tile_y      <= nxt_y;
                            pad_mod_sel <= mode_of(nxt_x, nxt_y, tiles_x_q, tiles_y_q);
                            state       <= S_ISSUE;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_tile_sched.sv
module tb_pool_tile_sched;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] cfg_tiles_x = '0;
    logic [3:0] cfg_tiles_y = '0;
    logic [5:0] cfg_tile_length = '0;
    logic [5:0] cfg_tile_height = '0;
    logic [2:0] cfg_ksize = '0;
    logic [2:0] cfg_stride = '0;
    logic [2:0] cfg_pad_size = '0;
    logic       glb_ready = 1'b1;
    logic       resp_pad = 1'b0;
    logic       resp_dump = 1'b0;
    logic       man_dump = 1'b0;
    logic       pad_end;
    logic       dump_end;

    logic [5:0] tile_length_to_qtf, tile_height_to_qtf;
    logic [2:0] ksize, stride, pad_size;
    logic [3:0] pad_mod_sel, tile_x, tile_y;
    logic       tile_go, tile_dump, busy, done, cfg_err;

    assign pad_end  = resp_pad;
    assign dump_end = resp_dump | man_dump;

    pool_tile_sched #(.POOL_SIZE(2), .MAX_DIM(31)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_tiles_x(cfg_tiles_x), .cfg_tiles_y(cfg_tiles_y),
        .cfg_tile_length(cfg_tile_length), .cfg_tile_height(cfg_tile_height),
        .cfg_ksize(cfg_ksize), .cfg_stride(cfg_stride), .cfg_pad_size(cfg_pad_size),
        .pad_end(pad_end), .dump_end(dump_end), .glb_ready(glb_ready),
        .tile_length_to_qtf(tile_length_to_qtf), .tile_height_to_qtf(tile_height_to_qtf),
        .ksize(ksize), .stride(stride), .pad_size(pad_size),
        .pad_mod_sel(pad_mod_sel), .tile_go(tile_go), .tile_dump(tile_dump),
        .tile_x(tile_x), .tile_y(tile_y), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int go_cnt = 0;
    int dump_cnt = 0;
    int done_cnt = 0;
    int obs_mode[32];
    bit auto_pad = 1'b1;
    bit auto_dump = 1'b1;

    // Expected observable events: 0 = tile_go, 1 = tile_dump, 2 = done.
    typedef struct {
        int kind;
        int mode;
        int x;
        int y;
        int err;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int mode_for(input int x, input int y, input int nx, input int ny);
        int r, c;
        r = (y == 0) ? 0 : ((y == ny - 1) ? 2 : 1);
        c = (x == 0) ? 0 : ((x == nx - 1) ? 2 : 1);
        return 3 * r + c + 1;
    endfunction

    function automatic bit cfg_ok(input int tx, input int ty, input int l, input int h,
                                  input int k, input int s, input int pad);
        int lp, hp;
        if (s == 0 || k == 0 || k > l || k > h || tx == 0 || ty == 0) return 1'b0;
        lp = ((l - k) / s + 1) / 2;
        hp = ((h - k) / s + 1) / 2;
        if (lp == 0 || hp == 0 || lp + pad > 31 || hp + pad > 31) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_ev(input int kind, input int mode, input int x, input int y, input int err);
        ev_t e;
        e.kind = kind; e.mode = mode; e.x = x; e.y = y; e.err = err;
        exp_q.push_back(e);
    endtask

    // Whole-layer expectation: one go/dump pair per tile in row-major order, then done.
    task automatic model_layer(input int tx, input int ty, input int l, input int h,
                               input int k, input int s, input int pad);
        if (!cfg_ok(tx, ty, l, h, k, s, pad)) begin
            push_ev(2, 0, 0, 0, 1);
        end else begin
            for (int y = 0; y < ty; y++) begin
                for (int x = 0; x < tx; x++) begin
                    push_ev(0, mode_for(x, y, tx, ty), x, y, 0);
                    push_ev(1, mode_for(x, y, tx, ty), x, y, 0);
                end
            end
            push_ev(2, 0, 0, 0, 0);
        end
    endtask

    task automatic compare_loop();
        ev_t e;
        int  kind;
        forever begin
            @(negedge clock);
            if (rst_n && (tile_go || tile_dump || done)) begin
                kind = tile_go ? 0 : (tile_dump ? 1 : 2);
                if (kind == 0) begin
                    obs_mode[go_cnt % 32] = int'(pad_mod_sel);
                    go_cnt++;
                end else if (kind == 1) begin
                    dump_cnt++;
                end else begin
                    done_cnt++;
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_event", kind, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", kind, e.kind);
                    if (kind < 2) begin
                        check("ev_pad_mod_sel", int'(pad_mod_sel), e.mode);
                        check("ev_tile_x", int'(tile_x), e.x);
                        check("ev_tile_y", int'(tile_y), e.y);
                        check("ev_busy", int'(busy), 1);
                    end else begin
                        check("done_cfg_err", int'(cfg_err), e.err);
                        check("done_busy", int'(busy), 0);
                    end
                end
            end
        end
    endtask

    // Pool buffer stand-in: answers tile_go with pad_end and tile_dump with dump_end 5 cycles later.
    task automatic responder();
        int pe = 0;
        int de = 0;
        forever begin
            @(negedge clock);
            resp_pad  = 1'b0;
            resp_dump = 1'b0;
            if (pe > 0) begin
                pe--;
                if (pe == 0) resp_pad = 1'b1;
            end
            if (de > 0) begin
                de--;
                if (de == 0) resp_dump = 1'b1;
            end
            if (tile_go && auto_pad) pe = 5;
            if (tile_dump && auto_dump) de = 5;
        end
    endtask

    task automatic set_cfg(input int tx, input int ty, input int l, input int h,
                           input int k, input int s, input int pad);
        cfg_tiles_x = 4'(tx); cfg_tiles_y = 4'(ty);
        cfg_tile_length = 6'(l); cfg_tile_height = 6'(h);
        cfg_ksize = 3'(k); cfg_stride = 3'(s); cfg_pad_size = 3'(pad);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int b = done_cnt;
        int n = 0;
        while (done_cnt == b && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (done_cnt == b) check("done_timeout", done_cnt - b, 1);
    endtask

    task automatic run_layer(input int tx, input int ty, input int l, input int h,
                             input int k, input int s, input int pad, input int budget);
        set_cfg(tx, ty, l, h, k, s, pad);
        model_layer(tx, ty, l, h, k, s, pad);
        pulse_start();
        wait_done(budget);
        repeat (10) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cfg_outs"}, int'({tile_length_to_qtf, tile_height_to_qtf, ksize, stride, pad_size}), 0);
        check({tag, "_ctl_outs"}, int'({pad_mod_sel, tile_go, tile_dump, tile_x, tile_y, busy, done, cfg_err}), 0);
    endtask

    initial begin
        int b_go, b_dump, b_done, n;
        int m4[4];
        m4 = '{1, 3, 7, 9};

        fork
            compare_loop();
            responder();
        join_none

        // Reset state
        #12;
        check_all_zero("reset");
        @(negedge clock);
        rst_n = 1'b1;
        repeat (2) @(negedge clock);

        // 2x2 grid, L=H=18 k=3 s=1 pad=1
        b_go = go_cnt; b_dump = dump_cnt; b_done = done_cnt;
        run_layer(2, 2, 18, 18, 3, 1, 1, 400);
        check("g2_go_count", go_cnt - b_go, 4);
        check("g2_dump_count", dump_cnt - b_dump, 4);
        check("g2_done_count", done_cnt - b_done, 1);
        for (int i = 0; i < 4; i++) check("g2_mode_seq", obs_mode[(b_go + i) % 32], m4[i]);
        check("g2_latched_len", int'(tile_length_to_qtf), 18);
        check("g2_latched_k", int'(ksize), 3);
        check("g2_latched_pad", int'(pad_size), 1);
        check("g2_cfg_err", int'(cfg_err), 0);

        // 3x3 grid: modes 1..9 in order
        b_go = go_cnt;
        run_layer(3, 3, 18, 18, 3, 1, 1, 800);
        check("g3_go_count", go_cnt - b_go, 9);
        for (int i = 0; i < 9; i++) check("g3_mode_seq", obs_mode[(b_go + i) % 32], i + 1);
        check("g3_final_x", int'(tile_x), 2);
        check("g3_final_y", int'(tile_y), 2);

        // Kernel larger than tile: error with done two cycles after start
        set_cfg(1, 1, 4, 4, 5, 1, 0);
        model_layer(1, 1, 4, 4, 5, 1, 0);
        b_go = go_cnt;
        pulse_start();
        check("err_done_early", int'(done), 0);
        @(negedge clock);
        check("err_done_2cyc", int'(done), 1);
        check("err_cfg_err", int'(cfg_err), 1);
        repeat (5) @(negedge clock);
        check("err_no_go", go_cnt - b_go, 0);
        check("err_sticky", int'(cfg_err), 1);

        // Pooled-size limits
        run_layer(1, 1, 34, 34, 3, 1, 2, 200);
        check("lp16_cfg_err", int'(cfg_err), 0);
        run_layer(1, 1, 63, 63, 1, 1, 0, 200);
        check("lp31_cfg_err", int'(cfg_err), 0);
        run_layer(1, 1, 63, 63, 1, 1, 1, 200);
        check("lp31_pad1_cfg_err", int'(cfg_err), 1);

        // glb_ready held low
        glb_ready = 1'b0;
        set_cfg(1, 1, 18, 18, 3, 1, 1);
        model_layer(1, 1, 18, 18, 3, 1, 1);
        b_dump = dump_cnt;
        pulse_start();
        repeat (35) @(negedge clock);
        check("glb_low_no_dump", dump_cnt - b_dump, 0);
        check("glb_low_busy", int'(busy), 1);
        glb_ready = 1'b1;
        @(negedge clock);
        check("glb_rise_dump", int'(tile_dump), 1);
        @(negedge clock);
        check("glb_dump_one_cycle", int'(tile_dump), 0);
        wait_done(100);
        repeat (10) @(negedge clock);

        // Abort while waiting for dump_end
        auto_dump = 1'b0;
        set_cfg(2, 2, 18, 18, 3, 1, 1);
        push_ev(0, 1, 0, 0, 0);
        push_ev(1, 1, 0, 0, 0);
        push_ev(2, 0, 0, 0, 0);
        b_go = go_cnt;
        pulse_start();
        n = 0;
        while (!tile_dump && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("abort_saw_dump", int'(tile_dump), 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        repeat (3) @(negedge clock);
        check("abort_held_busy", int'(busy), 1);
        man_dump = 1'b1;
        @(negedge clock);
        man_dump = 1'b0;
        check("abort_done_1cyc", int'(done), 1);
        check("abort_busy_clear", int'(busy), 0);
        repeat (10) @(negedge clock);
        check("abort_no_reissue", go_cnt - b_go, 1);
        auto_dump = 1'b1;

        // Reset in the middle of WAIT_POOL
        auto_pad = 1'b0;
        set_cfg(2, 2, 18, 18, 3, 1, 1);
        push_ev(0, 1, 0, 0, 0);
        pulse_start();
        n = 0;
        while (!tile_go && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("rst_saw_go", int'(tile_go), 1);
        repeat (2) @(negedge clock);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        rst_n = 1'b1;
        auto_pad = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_idle", int'(busy), 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
